// File: rtl/ps2_key_decoder_pkg.sv
// Shared key-event enum, PS/2 set-2 scan codes and decode helpers
// used by the PS/2 decoder, user_input and main_game_logic.
package ps2_key_decoder_pkg;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_DROP     = 3'd5,
    EV_NEW_GAME = 3'd6
  } key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_ROTATE   = 8'h75;
  localparam logic [7:0] SC_DROP     = 8'h29;
  localparam logic [7:0] SC_NEW_GAME = 8'h5A;

  function automatic key_event_t map_scan_code(
    input logic [7:0] sc,
    input logic       ext
  );
    key_event_t ev;
    ev = EV_NONE;
    if (ext) begin
      case (sc)
        SC_LEFT:   ev = EV_LEFT;
        SC_RIGHT:  ev = EV_RIGHT;
        SC_DOWN:   ev = EV_DOWN;
        SC_ROTATE: ev = EV_ROTATE;
        default:   ev = EV_NONE;
      endcase
    end else begin
      case (sc)
        SC_DROP:     ev = EV_DROP;
        SC_NEW_GAME: ev = EV_NEW_GAME;
        default:     ev = EV_NONE;
      endcase
    end
    return ev;
  endfunction

  function automatic logic is_movement(input key_event_t ev);
    return (ev == EV_LEFT) || (ev == EV_RIGHT) ||
           (ev == EV_DOWN);
  endfunction

  // One-hot bit of a key in the pressed[6:1] mask; EV_NONE maps to 0.
  function automatic logic [6:1] key_mask(input key_event_t ev);
    logic [7:0] oh;
    oh = 8'd1 << ev;
    return oh[6:1];
  endfunction

endpackage

// File: rtl/ps2_key_decoder_repeat_timer.sv
// Auto-repeat timer for the most recently pressed movement key.
// Emits a repeat request when the down-counter reaches 1.
module key_repeat_timer
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       make_en_i,
  input  key_event_t make_key_i,
  input  logic       brk_en_i,
  input  key_event_t brk_key_i,
  output logic       repeat_en_o,
  output key_event_t held_key_o
);

  localparam int unsigned MAX_LOAD =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                   : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_LOAD + 1);

  logic [CW-1:0] cnt;
  logic          held_brk;
  logic          expire;

  assign held_brk = brk_en_i && (brk_key_i == held_key_o) &&
                    (held_key_o != EV_NONE);
  assign expire   = (held_key_o != EV_NONE) &&
                    (cnt == CW'(1));

  // A same-cycle make or release of the held key wins over expiry.
  assign repeat_en_o = expire && !make_en_i && !held_brk;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      held_key_o <= EV_NONE;
      cnt        <= '0;
    end else if (make_en_i && is_movement(make_key_i)) begin
      held_key_o <= make_key_i;
      cnt        <= CW'(REPEAT_DELAY);
    end else if (held_brk) begin
      held_key_o <= EV_NONE;
      cnt        <= '0;
    end else if (held_key_o != EV_NONE) begin
      if (cnt <= CW'(1))
        cnt <= CW'(REPEAT_PERIOD);
      else
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to game key events: E0/F0 prefix FSM,
// pressed-key mask, typematic filter and movement auto-repeat.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] ps2_key_data_i,
  input  logic       ps2_key_data_en_i,
  output key_event_t key_event_o,
  output logic       key_event_en_o
);

  prefix_state_t state;
  prefix_state_t next_state;
  logic          final_byte;
  logic          ext;
  logic          brk;
  key_event_t    code;
  logic [6:1]    mask;
  logic [6:1]    pressed;
  logic          hit;
  logic          make_en;
  logic          brk_en;
  logic          repeat_en;
  key_event_t    held_key;

  always_comb begin
    next_state = ST_IDLE;
    final_byte = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ps2_key_data_i == SC_EXT)
          next_state = ST_EXT;
        else if (ps2_key_data_i == SC_BRK)
          next_state = ST_BRK;
        else
          final_byte = 1'b1;
      end
      ST_EXT: begin
        if (ps2_key_data_i == SC_EXT)
          next_state = ST_EXT;
        else if (ps2_key_data_i == SC_BRK)
          next_state = ST_EXT_BRK;
        else
          final_byte = 1'b1;
      end
      ST_BRK: begin
        if (ps2_key_data_i == SC_BRK)
          next_state = ST_BRK;
        else
          final_byte = 1'b1;
      end
      default: final_byte = 1'b1;
    endcase
  end

  assign ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign code = map_scan_code(ps2_key_data_i, ext);
  assign mask = key_mask(code);
  assign hit  = ps2_key_data_en_i && final_byte &&
                (code != EV_NONE);

  // Typematic makes of an already-pressed key are dropped here.
  assign make_en = hit && !brk && ((pressed & mask) == '0);
  assign brk_en  = hit && brk;

  key_repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .make_en_i   (make_en),
    .make_key_i  (code),
    .brk_en_i    (brk_en),
    .brk_key_i   (code),
    .repeat_en_o (repeat_en),
    .held_key_o  (held_key)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= ST_IDLE;
      pressed        <= '0;
      key_event_o    <= EV_NONE;
      key_event_en_o <= 1'b0;
    end else begin
      key_event_en_o <= 1'b0;
      if (ps2_key_data_en_i)
        state <= next_state;
      if (make_en) begin
        pressed        <= pressed | mask;
        key_event_o    <= code;
        key_event_en_o <= 1'b1;
      end else if (brk_en) begin
        pressed <= pressed & ~mask;
      end
      if (repeat_en) begin
        key_event_o    <= held_key;
        key_event_en_o <= 1'b1;
      end
    end
  end

endmodule
